// File: rtl/array_accu_pkg.sv
// rtl/array_accu_pkg.sv - shared types, constants and helpers for the array accumulator
// Contents: state_t (IDLE/ACCUM/RESULT), default widths, LANES, lane_lo() lane-slice helper.
// Optional feature macro used by this slice: ARRAY_ACCU_SAT_EN (saturating lane add).
package array_accu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    RESULT = 2'd2
  } state_t;

  localparam int CACHE_WIDTH_DEF = 512;
  localparam int DATA_WIDTH_DEF  = 32;
  localparam int LEN_WIDTH_DEF   = 16;
  localparam int LANES           = CACHE_WIDTH_DEF / DATA_WIDTH_DEF;

  // Low bit index of lane 'lane' in a line of dw-bit lanes.
  function automatic int lane_lo(input int lane, input int dw);
    return lane * dw;
  endfunction

endpackage

// File: rtl/array_accu_lanes.sv
// rtl/array_accu_lanes.sv - per-lane load/add datapath for one cache line
// Ports: load (pass in_data through, first beat of a job), acc (running sum),
//        in_data (new line), sum (next accumulator value), clamp (any lane saturated).
// ARRAY_ACCU_SAT_EN defined: unsigned saturating lane add; otherwise wrap-around.
module array_accu_lanes
  import array_accu_pkg::*;
#(
  parameter int CACHE_WIDTH = CACHE_WIDTH_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF
) (
  input  logic                   load,
  input  logic [CACHE_WIDTH-1:0] acc,
  input  logic [CACHE_WIDTH-1:0] in_data,
  output logic [CACHE_WIDTH-1:0] sum,
  output logic                   clamp
);

  localparam int NL = CACHE_WIDTH / DATA_WIDTH;

  logic [NL-1:0] lane_clamp;

  for (genvar g = 0; g < NL; g++) begin : g_lane
    localparam int LO = lane_lo(g, DATA_WIDTH);
`ifdef ARRAY_ACCU_SAT_EN
    // One extra bit captures the carry-out that signals the lane overflowed.
    logic [DATA_WIDTH:0] wide;
    assign wide = {1'b0, acc[LO +: DATA_WIDTH]} + {1'b0, in_data[LO +: DATA_WIDTH]};
    assign lane_clamp[g] = !load && wide[DATA_WIDTH];
    assign sum[LO +: DATA_WIDTH] = load ? in_data[LO +: DATA_WIDTH] :
                                   (wide[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : wide[DATA_WIDTH-1:0]);
`else
    assign lane_clamp[g] = 1'b0;
    assign sum[LO +: DATA_WIDTH] = load ? in_data[LO +: DATA_WIDTH] :
                                   acc[LO +: DATA_WIDTH] + in_data[LO +: DATA_WIDTH];
`endif
  end

  assign clamp = |lane_clamp;

endmodule

// File: rtl/array_accu_ctrl.sv
// rtl/array_accu_ctrl.sv - job sequencer summing a stream of cache lines per lane
// Ports: clk, rst (sync, active-high); start/len/abort job control; busy status;
//        in_valid/in_data/in_ready line stream; res_valid/res_data/res_ready result;
//        beat_cnt lines consumed this job; res_sat sticky per-job saturation flag.
// ARRAY_ACCU_SAT_EN defined: saturating lanes and live res_sat; otherwise res_sat stays 0.
module array_accu_ctrl
  import array_accu_pkg::*;
#(
  parameter int CACHE_WIDTH = CACHE_WIDTH_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int LEN_WIDTH   = LEN_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LEN_WIDTH-1:0]   len,
  input  logic                   abort,
  output logic                   busy,
  input  logic                   in_valid,
  input  logic [CACHE_WIDTH-1:0] in_data,
  output logic                   in_ready,
  output logic                   res_valid,
  output logic [CACHE_WIDTH-1:0] res_data,
  input  logic                   res_ready,
  output logic [LEN_WIDTH-1:0]   beat_cnt,
  output logic                   res_sat
);

  state_t                 state, state_nx;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [CACHE_WIDTH-1:0] acc, sum;
  logic                   clamp, beat, last_beat;

  assign beat      = (state == ACCUM) && in_valid;
  assign last_beat = beat && (beat_cnt == len_q - LEN_WIDTH'(1));

  array_accu_lanes #(
    .CACHE_WIDTH (CACHE_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_lanes (
    .load    (beat_cnt == '0),
    .acc     (acc),
    .in_data (in_data),
    .sum     (sum),
    .clamp   (clamp)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) state_nx = (len != '0) ? ACCUM : RESULT;
      end
      ACCUM: begin
        if (abort)          state_nx = IDLE;
        else if (last_beat) state_nx = RESULT;
      end
      RESULT: begin
        // abort and a handshake both land in IDLE, so no priority is needed here.
        if (abort || res_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    case (state)
      ACCUM:   begin busy = 1'b1; in_ready  = 1'b1; end
      RESULT:  begin busy = 1'b1; res_valid = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      beat_cnt <= '0;
      len_q    <= '0;
      res_sat  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc      <= '0;
            beat_cnt <= '0;
            len_q    <= len;
            res_sat  <= 1'b0;
          end
        end
        ACCUM: begin
          // A beat on the abort cycle is dropped together with the job.
          if (abort) begin
            acc <= '0;
          end else if (beat) begin
            acc      <= sum;
            beat_cnt <= beat_cnt + LEN_WIDTH'(1);
            res_sat  <= res_sat | clamp;
          end
        end
        RESULT: begin
          if (abort) acc <= '0;
        end
        default: ;
      endcase
    end
  end

  assign res_data = acc;

endmodule
